commit_controller: RTL

Sequences the back-end after instructions retire from the reorder buffer. It inspects the committed slots each cycle and decides whether to flush the pipeline and where to redirect fetch: branch mispredict, exception, ertn, refetch-type privileged, ibar or icacop instructions, idle, or an interrupt. It drives the global flush, the fetch redirect, the CSR exception/ertn strobes and the idle stall. It sits between the ROB commit port and the frontend/CSR file.

---
 rtl/commit_controller_pkg.sv | 6 +
 rtl/commit_controller_if.sv | 20 ++
 rtl/commit_event_picker.sv | 36 +++
 rtl/commit_controller.sv | 92 +++++++++
 4 files changed

// File: rtl/commit_controller_pkg.sv
// commit_controller_pkg: shared state, event-kind and ecode definitions for the commit controller
package commit_controller_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, IDLE} CmtCtrlState;
  typedef enum logic [2:0] {EV_NONE, EV_EXCP, EV_ERTN, EV_REDIRECT, EV_IDLE, EV_REFETCH} cmt_event_e;
  localparam logic [5:0] ECODE_INT = 6'h00;
endpackage

// File: rtl/commit_controller_if.sv
// commit_controller_if: ROB commit port carrying the retired slots and their flush-relevant flags
interface commit_controller_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int PC_W         = 32,
  parameter int ECODE_W      = 6
);
  logic [COMMIT_WIDTH-1:0]              cmt_valid;
  logic [COMMIT_WIDTH-1:0][PC_W-1:0]    cmt_pc;
  logic [COMMIT_WIDTH-1:0]              cmt_excp;
  logic [COMMIT_WIDTH-1:0][ECODE_W-1:0] cmt_ecode;
  logic [COMMIT_WIDTH-1:0]              cmt_redirect;
  logic [COMMIT_WIDTH-1:0][PC_W-1:0]    cmt_br_target;
  logic [COMMIT_WIDTH-1:0]              cmt_refetch;
  logic [COMMIT_WIDTH-1:0]              cmt_ertn;
  logic [COMMIT_WIDTH-1:0]              cmt_idle;
  modport master (output cmt_valid, cmt_pc, cmt_excp, cmt_ecode, cmt_redirect, cmt_br_target,
                  cmt_refetch, cmt_ertn, cmt_idle);
  modport slave  (input  cmt_valid, cmt_pc, cmt_excp, cmt_ecode, cmt_redirect, cmt_br_target,
                  cmt_refetch, cmt_ertn, cmt_idle);
endinterface

// File: rtl/commit_event_picker.sv
// commit_event_picker: picks the lowest-index eventful slot and resolves its kind and fetch target
module commit_event_picker
  import commit_controller_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2,
  parameter int PC_W         = 32,
  parameter int IDX_W        = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  logic [COMMIT_WIDTH-1:0]           valid,
  input  logic [COMMIT_WIDTH-1:0][PC_W-1:0] pc,
  input  logic [COMMIT_WIDTH-1:0]           excp,
  input  logic [COMMIT_WIDTH-1:0]           ertn,
  input  logic [COMMIT_WIDTH-1:0]           redirect,
  input  logic [COMMIT_WIDTH-1:0][PC_W-1:0] br_target,
  input  logic [COMMIT_WIDTH-1:0]           idle,
  input  logic [COMMIT_WIDTH-1:0]           refetch,
  input  logic [PC_W-1:0]                   eentry,
  input  logic [PC_W-1:0]                   era,
  output logic [IDX_W-1:0]                  slot,
  output cmt_event_e                        kind,
  output logic [PC_W-1:0]                   target
);
  // Scanning downward lets the lowest eventful slot overwrite any higher one.
  always_comb begin
    slot   = '0;
    kind   = EV_NONE;
    target = '0;
    for (int i = COMMIT_WIDTH - 1; i >= 0; i--)
      if (valid[i] && (excp[i] || ertn[i] || redirect[i] || idle[i] || refetch[i])) begin
        slot   = IDX_W'(i);
        kind   = excp[i] ? EV_EXCP : ertn[i] ? EV_ERTN : redirect[i] ? EV_REDIRECT :
                 idle[i] ? EV_IDLE : EV_REFETCH;
        target = excp[i] ? eentry : ertn[i] ? era : redirect[i] ? br_target[i] : pc[i] + PC_W'(4);
      end
  end
endmodule

// File: rtl/commit_controller.sv
// commit_controller: turns retired-slot events and interrupts into flush, redirect, CSR and idle controls
module commit_controller
  import commit_controller_pkg::*;
#(
  parameter int              COMMIT_WIDTH = 2,
  parameter int              PC_W         = 32,
  parameter int              ECODE_W      = 6,
  parameter logic [PC_W-1:0] RESET_PC     = 32'h1c00_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  commit_controller_if.slave    cmt,
  input  logic                  has_int,
  input  logic [PC_W-1:0]       eentry,
  input  logic [PC_W-1:0]       era,
  output logic                  flush_o,
  output logic                  redirect_valid_o,
  output logic [PC_W-1:0]       redirect_pc_o,
  output logic                  excp_valid_o,
  output logic [ECODE_W-1:0]    excp_ecode_o,
  output logic [PC_W-1:0]       excp_pc_o,
  output logic                  ertn_o,
  output logic                  idle_o
);
  localparam int IDX_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
  CmtCtrlState       state, state_n;
  cmt_event_e        ev_kind;
  logic [IDX_W-1:0]  ev_slot;
  logic [PC_W-1:0]   ev_target, last_pc4, next_pc, next_pc_n, redir_pc_n, epc_n;
  logic [ECODE_W-1:0] ecode_n;
  logic              ev_go, int_go, flush_n, excp_v_n, ertn_n, idle_n;
  commit_event_picker #(.COMMIT_WIDTH(COMMIT_WIDTH), .PC_W(PC_W), .IDX_W(IDX_W)) u_picker (
    .valid     (cmt.cmt_valid),
    .pc        (cmt.cmt_pc),
    .excp      (cmt.cmt_excp),
    .ertn      (cmt.cmt_ertn),
    .redirect  (cmt.cmt_redirect),
    .br_target (cmt.cmt_br_target),
    .idle      (cmt.cmt_idle),
    .refetch   (cmt.cmt_refetch),
    .eentry    (eentry),
    .era       (era),
    .slot      (ev_slot),
    .kind      (ev_kind),
    .target    (ev_target)
  );
  // With nothing valid the fall-through PC is simply the tracked next_pc.
  always_comb begin
    last_pc4 = next_pc;
    for (int i = 0; i < COMMIT_WIDTH; i++)
      if (cmt.cmt_valid[i]) last_pc4 = cmt.cmt_pc[i] + PC_W'(4);
  end
  always_comb begin
    ev_go      = state == RUN && ev_kind != EV_NONE;
    int_go     = has_int && (state == IDLE || (state == RUN && ev_kind == EV_NONE));
    state_n    = ev_go ? (ev_kind == EV_IDLE ? IDLE : FLUSH) : int_go ? FLUSH :
                 state == FLUSH ? RUN : state;
    flush_n    = ev_go || int_go;
    redir_pc_n = ev_go ? ev_target : int_go ? eentry : redirect_pc_o;
    next_pc_n  = flush_n ? redir_pc_n : state == RUN ? last_pc4 : next_pc;
    excp_v_n   = (ev_go && ev_kind == EV_EXCP) || int_go;
    ecode_n    = (ev_go && ev_kind == EV_EXCP) ? cmt.cmt_ecode[ev_slot] :
                 int_go ? ECODE_W'(ECODE_INT) : excp_ecode_o;
    epc_n      = (ev_go && ev_kind == EV_EXCP) ? cmt.cmt_pc[ev_slot] :
                 int_go ? (state == IDLE ? next_pc : last_pc4) : excp_pc_o;
    ertn_n     = ev_go && ev_kind == EV_ERTN;
    idle_n     = ev_go ? ev_kind == EV_IDLE : int_go ? 1'b0 : idle_o;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= RUN;
      next_pc       <= RESET_PC;
      flush_o       <= 1'b0;
      redirect_pc_o <= '0;
      excp_valid_o  <= 1'b0;
      excp_ecode_o  <= '0;
      excp_pc_o     <= '0;
      ertn_o        <= 1'b0;
      idle_o        <= 1'b0;
    end else begin
      state         <= state_n;
      next_pc       <= next_pc_n;
      flush_o       <= flush_n;
      redirect_pc_o <= redir_pc_n;
      excp_valid_o  <= excp_v_n;
      excp_ecode_o  <= ecode_n;
      excp_pc_o     <= epc_n;
      ertn_o        <= ertn_n;
      idle_o        <= idle_n;
    end
  assign redirect_valid_o = flush_o;
endmodule
